// File: rtl/fifo_read_unpacker_if.sv
// Read-port and serial-stream signals of the buffer read unpacker.
// The unpacker uses the master view; the surrounding logic uses the slave view.
interface fifo_read_unpacker_if #(
    parameter int WIDTH = 8,
    parameter int J     = 4
);
    logic                   fifo_empty;
    logic                   fifo_valid;
    logic [WIDTH*J-1:0]     fifo_data;
    logic                   fifo_r_en;
    logic [WIDTH-1:0]       ser_out;
    logic                   ser_valid;
    logic                   ser_ready;
    logic                   busy;
    logic [$clog2(J)-1:0]   lane_idx;
    logic                   err;

    modport master (
        input  fifo_empty, fifo_valid, fifo_data, ser_ready,
        output fifo_r_en, ser_out, ser_valid, busy, lane_idx, err
    );

    modport slave (
        output fifo_empty, fifo_valid, fifo_data, ser_ready,
        input  fifo_r_en, ser_out, ser_valid, busy, lane_idx, err
    );
endinterface

// File: rtl/fifo_read_unpacker.sv
// Reads one J-lane word from the parallel buffer and serialises it lane 0 first
// onto a WIDTH-bit valid/ready stream; flags read timeouts and spurious data.
module fifo_read_unpacker #(
    parameter int WIDTH   = 8,
    parameter int J       = 4,
    parameter int TIMEOUT = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    fifo_read_unpacker_if.master bus
);
    localparam int LW = $clog2(J);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [LW-1:0] LAST_LANE   = LW'(J - 1);
    localparam logic [CW-1:0] TIMEOUT_CNT = CW'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        SEND
    } state_t;

    state_t                  state, state_d;
    logic [J-1:0][WIDTH-1:0] hold, hold_d;
    logic [LW-1:0]           lane_idx, lane_d;
    logic [CW-1:0]           cnt, cnt_d;
    logic                    err, err_d;

    // NOTE: the holding register is reset along with the control state so a
    // stale word can never reappear on ser_out after an aborted transfer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            hold     <= '0;
            lane_idx <= '0;
            cnt      <= '0;
            err      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // values from before this edge, independent of statement order.
            state    <= state_d;
            hold     <= hold_d;
            lane_idx <= lane_d;
            cnt      <= cnt_d;
            err      <= err_d;
        end
    end

    always_comb begin
        // NOTE: every signal gets a hold-value default first, so no path
        // through the case leaves one unassigned and no latch is inferred.
        state_d = state;
        hold_d  = hold;
        lane_d  = lane_idx;
        cnt_d   = cnt;
        err_d   = err;

        // Data the buffer pushes when no read is outstanding is ignored but flagged.
        if (bus.fifo_valid && state != WAIT) begin
            err_d = 1'b1;
        end

        unique case (state)
            IDLE: begin
                if (!bus.fifo_empty) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                state_d = WAIT;
                cnt_d   = '0;
            end
            WAIT: begin
                if (bus.fifo_valid) begin
                    hold_d  = bus.fifo_data;
                    lane_d  = '0;
                    state_d = SEND;
                end else begin
                    cnt_d = cnt + 1'b1;
                    if (cnt_d == TIMEOUT_CNT) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            SEND: begin
                if (bus.ser_ready) begin
                    if (lane_idx == LAST_LANE) begin
                        lane_d  = '0;
                        // Chain straight into the next read when more data waits.
                        state_d = bus.fifo_empty ? IDLE : REQ;
                    end else begin
                        lane_d = lane_idx + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.fifo_r_en = (state == REQ);
    assign bus.ser_valid = (state == SEND);
    assign bus.ser_out   = hold[lane_idx];
    assign bus.busy      = (state != IDLE);
    assign bus.lane_idx  = lane_idx;
    assign bus.err       = err;
endmodule

// File: tb/tb_fifo_read_unpacker.sv
// Cycle-based bench for fifo_read_unpacker: a small buffer model answers read
// requests, expected lanes go into a scoreboard queue and are popped on transfers.
module tb_fifo_read_unpacker;
    localparam int WIDTH   = 8;
    localparam int J       = 4;
    localparam int TIMEOUT = 8;

    typedef struct packed {
        logic [7:0] data;
        logic [1:0] lane;
    } sb_t;

    typedef struct {
        logic [31:0] word;
        logic [7:0]  rdy_pat;
        logic [7:0]  exp_lane [4];
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fifo_read_unpacker_if #(.WIDTH(WIDTH), .J(J)) bus ();

    fifo_read_unpacker #(.WIDTH(WIDTH), .J(J), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          errors = 0;
    int          checks = 0;
    int          smp = 0;
    logic [31:0] buf_q [$];
    sb_t         sb [$];
    logic        mute = 1'b0;
    logic [7:0]  rdy_pat = 8'hFF;

    int          ren_count, sv_count, busy_count, first_sv, push_smp;
    int          ren_smps [$];
    int          xfer_smps [$];
    logic        prev_stall;
    logic [7:0]  prev_out;
    logic        s_ren, s_sv, s_busy, s_err, s_rdy;
    logic [7:0]  s_out;
    logic [1:0]  s_lane;

    vec_t        vecs [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at sample %0d",
                     name, act, act, exp, exp, smp);
        end
    endtask

    task automatic clear_stats();
        ren_count  = 0;
        sv_count   = 0;
        busy_count = 0;
        first_sv   = -1;
        push_smp   = -1;
        prev_stall = 1'b0;
        ren_smps.delete();
        xfer_smps.delete();
    endtask

    task automatic drive_idle_inputs();
        bus.fifo_empty = 1'b1;
        bus.fifo_valid = 1'b0;
        bus.fifo_data  = '0;
        bus.ser_ready  = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        buf_q.delete();
        sb.delete();
        mute    = 1'b0;
        rdy_pat = 8'hFF;
        drive_idle_inputs();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        clear_stats();
    endtask

    task automatic push_word(input logic [31:0] word, input logic [7:0] exp [4], input logic track);
        sb_t e;
        buf_q.push_back(word);
        if (track) begin
            for (int i = 0; i < 4; i++) begin
                e.data = exp[i];
                e.lane = 2'(i);
                sb.push_back(e);
            end
        end
        if (push_smp < 0) push_smp = smp + 1;
        bus.fifo_empty = 1'b0;
        bus.ser_ready  = rdy_pat[sv_count % 8];
    endtask

    // One clock: sample outputs at the falling edge, then model the buffer
    // response and drive the next inputs just after the rising edge.
    task automatic cycle();
        sb_t e;
        @(negedge clk);
        smp++;
        s_ren  = bus.fifo_r_en;
        s_sv   = bus.ser_valid;
        s_out  = bus.ser_out;
        s_lane = bus.lane_idx;
        s_busy = bus.busy;
        s_err  = bus.err;
        s_rdy  = bus.ser_ready;

        if (prev_stall) begin
            check("stall_valid_held", 32'(s_sv), 1);
            check("stall_data_held", 32'(s_out), 32'(prev_out));
        end
        if (s_ren) begin
            ren_count++;
            ren_smps.push_back(smp);
            check("ren_while_nonempty", 32'(buf_q.size() > 0), 1);
        end
        if (s_sv) begin
            if (first_sv < 0) first_sv = smp;
            sv_count++;
        end
        busy_count += int'(s_busy);
        if (s_sv && s_rdy) begin
            xfer_smps.push_back(smp);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("lane_data", 32'(s_out), 32'(e.data));
                check("lane_idx", 32'(s_lane), 32'(e.lane));
            end else begin
                check("unexpected_xfer_sb_size", 32'(sb.size()), 1);
            end
        end
        prev_stall = s_sv && !s_rdy;
        prev_out   = s_out;

        @(posedge clk);
        #1;
        if (s_ren && buf_q.size() > 0) begin
            bus.fifo_data  = buf_q.pop_front();
            bus.fifo_valid = !mute;
        end else begin
            bus.fifo_valid = 1'b0;
            bus.fifo_data  = $urandom;
        end
        bus.fifo_empty = (buf_q.size() == 0);
        bus.ser_ready  = rdy_pat[sv_count % 8];
    endtask

    task automatic drain(input string tag);
        logic done = 1'b0;
        for (int i = 0; i < 200; i++) begin
            cycle();
            if (sb.size() == 0 && buf_q.size() == 0 && !s_busy && !bus.fifo_valid) begin
                done = 1'b1;
                break;
            end
        end
        check($sformatf("%s_drain", tag), 32'(done), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, expected bench to finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] lanes [4];
        logic       hit;
        int         err_smp;
        int         err_low;

        vecs[0].word = 32'h0A0F190C; vecs[0].rdy_pat = 8'hFF;
        vecs[0].exp_lane = '{8'd12, 8'd25, 8'd15, 8'd10};
        vecs[1].word = 32'h0A0F190C; vecs[1].rdy_pat = 8'b1110_1001;
        vecs[1].exp_lane = '{8'd12, 8'd25, 8'd15, 8'd10};
        vecs[2].word = 32'hFF008001; vecs[2].rdy_pat = 8'b0101_0101;
        vecs[2].exp_lane = '{8'h01, 8'h80, 8'h00, 8'hFF};
        vecs[3].word = 32'hA55A3CC3; vecs[3].rdy_pat = 8'b1001_1011;
        vecs[3].exp_lane = '{8'hC3, 8'h3C, 8'h5A, 8'hA5};

        // Reset with random inputs: every output must read zero.
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.fifo_empty = 1'($urandom_range(0, 1));
            bus.fifo_valid = 1'($urandom_range(0, 1));
            bus.fifo_data  = $urandom;
            bus.ser_ready  = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("rst_fifo_r_en", 32'(bus.fifo_r_en), 0);
            check("rst_ser_valid", 32'(bus.ser_valid), 0);
            check("rst_ser_out", 32'(bus.ser_out), 0);
            check("rst_lane_idx", 32'(bus.lane_idx), 0);
            check("rst_busy", 32'(bus.busy), 0);
            check("rst_err", 32'(bus.err), 0);
        end
        drive_idle_inputs();
        @(posedge clk);
        #1 rst = 1'b1;
        clear_stats();
        repeat (20) cycle();
        check("idle_no_ren", 32'(ren_count), 0);
        check("idle_not_busy", 32'(busy_count), 0);

        // Table-driven single words with varying back-pressure.
        for (int v = 0; v < 4; v++) begin
            clear_stats();
            rdy_pat = vecs[v].rdy_pat;
            lanes   = vecs[v].exp_lane;
            push_word(vecs[v].word, lanes, 1'b1);
            drain($sformatf("vec%0d", v));
            check($sformatf("vec%0d_ren_pulses", v), 32'(ren_count), 1);
            check($sformatf("vec%0d_xfers", v), 32'(xfer_smps.size()), 4);
            if (ren_smps.size() > 0) begin
                check($sformatf("vec%0d_ren_latency", v), 32'(ren_smps[0]), 32'(push_smp + 1));
                check($sformatf("vec%0d_sv_latency", v), 32'(first_sv), 32'(ren_smps[0] + 2));
            end
            check($sformatf("vec%0d_idle_after", v), 32'(s_busy), 0);
            check($sformatf("vec%0d_err_clear", v), 32'(s_err), 0);
        end

        // Back-to-back words: no IDLE bubble, J+2 cycles per word.
        clear_stats();
        rdy_pat = 8'hFF;
        lanes = '{8'd1, 8'd2, 8'd3, 8'd4};
        push_word(32'h04030201, lanes, 1'b1);
        lanes = '{8'd5, 8'd6, 8'd7, 8'd8};
        push_word(32'h08070605, lanes, 1'b1);
        drain("b2b");
        check("b2b_ren_pulses", 32'(ren_count), 2);
        check("b2b_xfers", 32'(xfer_smps.size()), 8);
        if (ren_smps.size() == 2 && xfer_smps.size() == 8) begin
            check("b2b_second_ren_after_lane3", 32'(ren_smps[1]), 32'(xfer_smps[3] + 1));
            check("b2b_word_period", 32'(ren_smps[1] - ren_smps[0]), J + 2);
            check("b2b_total_span", 32'(xfer_smps[7] - ren_smps[0]), 2 * (J + 2) - 1);
        end

        // Read timeout: the buffer never answers.
        clear_stats();
        mute = 1'b1;
        lanes = '{8'd0, 8'd0, 8'd0, 8'd0};
        push_word(32'hDEADBEEF, lanes, 1'b0);
        err_smp = -1;
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (s_err && err_smp < 0) begin
                err_smp = smp;
                check("timeout_back_to_idle", 32'(s_busy), 0);
                break;
            end
        end
        check("timeout_ren_pulses", 32'(ren_count), 1);
        if (ren_smps.size() > 0) begin
            check("timeout_err_cycle", 32'(err_smp), 32'(ren_smps[0] + 1 + TIMEOUT));
        end
        mute = 1'b0;
        err_low = 0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (!s_err) err_low++;
        end
        check("timeout_err_sticky", 32'(err_low), 0);
        check("timeout_stays_idle", 32'(s_busy), 0);
        do_reset();
        cycle();
        check("err_cleared_by_reset", 32'(s_err), 0);

        // Spurious valid while IDLE: flagged, not serialised.
        clear_stats();
        bus.fifo_valid = 1'b1;
        bus.fifo_data  = 32'h12345678;
        cycle();
        cycle();
        check("spurious_err", 32'(s_err), 1);
        check("spurious_no_ser_valid", 32'(sv_count), 0);
        check("spurious_not_busy", 32'(busy_count), 0);
        check("spurious_no_ren", 32'(ren_count), 0);

        // Reset while lane 2 is presented aborts at once; next word restarts at lane 0.
        clear_stats();
        rdy_pat = 8'hFF;
        lanes = '{8'h11, 8'h22, 8'h33, 8'h44};
        push_word(32'h44332211, lanes, 1'b1);
        hit = 1'b0;
        for (int i = 0; i < 30; i++) begin
            cycle();
            if (bus.ser_valid === 1'b1 && bus.lane_idx === 2'd2) begin
                hit = 1'b1;
                break;
            end
        end
        check("midrst_reached_lane2", 32'(hit), 1);
        rst = 1'b0;
        #1;
        check("midrst_ser_valid", 32'(bus.ser_valid), 0);
        check("midrst_ser_out", 32'(bus.ser_out), 0);
        check("midrst_lane_idx", 32'(bus.lane_idx), 0);
        check("midrst_busy", 32'(bus.busy), 0);
        check("midrst_fifo_r_en", 32'(bus.fifo_r_en), 0);
        check("midrst_err", 32'(bus.err), 0);
        buf_q.delete();
        sb.delete();
        drive_idle_inputs();
        @(posedge clk);
        #1 rst = 1'b1;
        clear_stats();
        lanes = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        push_word(32'hDDCCBBAA, lanes, 1'b1);
        drain("after_midrst");
        check("after_midrst_ren_pulses", 32'(ren_count), 1);
        check("after_midrst_xfers", 32'(xfer_smps.size()), 4);
        if (ren_smps.size() > 0) begin
            check("after_midrst_sv_latency", 32'(first_sv), 32'(ren_smps[0] + 2));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
